// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch FSM state type and instruction field constants
//
// Purpose : types and constants shared by the fetch unit and its neighbours
//           (control unit decode uses the opcode field position and opcodes).
// Contents: state_t      - fetch FSM state encoding
//           OPCODE_MSB/LSB - opcode field position inside an instruction word
//           OPCODE_J/M   - opcode values referenced by the control unit
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;

    localparam logic [4:0] OPCODE_J = 5'b00011;
    localparam logic [4:0] OPCODE_M = 5'b00100;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with PC update and optional ack timeout
//
// Purpose : fetches one instruction word at a time from instruction memory,
//           presents it downstream with a valid/ready handshake and computes
//           the next PC (sequential, absolute redirect or PC-relative redirect)
//           when the instruction is consumed.
// Config  : `define FETCH_TIMEOUT_EN to enable the ack wait limit. With it, a
//           request left unacknowledged for TIMEOUT_CYCLES cycles parks the
//           unit in ERR with fetch_err set until RST. Without it, fetch_err is
//           constant 0 and a request waits indefinitely.
// Ports   : CLK, RST              - clock, synchronous active-high reset
//           imem_req/imem_addr    - memory read request and word address
//           imem_ack/imem_rdata   - memory read completion and data
//           instr/opcode/pc_out   - registered instruction, its opcode and address
//           instr_valid/instr_ready - downstream handshake
//           pcSrc/C_offset/redirect_imm - next-PC control, used on handshake only
//           fetch_err             - sticky timeout flag
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [4:0]  opcode,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pcSrc,
    input  logic        C_offset,
    input  logic [31:0] redirect_imm,
    output logic        fetch_err
);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] next_pc;

    // The PC register is the request address; it only changes while no
    // request is outstanding, so the address stays stable through REQ.
    assign imem_addr = pc;
    assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];

    // Next PC is relative to the consumed instruction's address, not to the
    // PC register (which already equals pc_out in VALID, but pc_out is the
    // architectural reference).
    always_comb begin
        next_pc = pc_out + 32'd1;
        if (pcSrc) begin
            if (C_offset) begin
                next_pc = pc_out + 32'd1 + redirect_imm;
            end else begin
                next_pc = redirect_imm;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        err_q;
    assign fetch_err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0);
    assign fetch_err  = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= 32'h0;
            pc_out      <= RESET_PC;
            instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt    <= 32'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt <= 32'd0;
`endif
                end
                S_REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= S_VALID;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_CYCLES - 1) begin
                        imem_req <= 1'b0;
                        err_q    <= 1'b1;
                        state    <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
`endif
                end
                S_VALID: begin
                    // instr_valid is always 1 here, so ready alone is the handshake.
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= next_pc;
                        imem_req    <= 1'b1;
                        state       <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt    <= 32'd0;
`endif
                    end
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a PC reference model
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [4:0]  opcode;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        pcSrc = 1'b0;
    logic        C_offset = 1'b0;
    logic [31:0] redirect_imm = 32'h0;
    logic        fetch_err;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_pc;

    int          mem_lat = 0;
    logic        mem_dead = 1'b0;
    int          mem_cnt = 0;

    fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .pc_out(pc_out),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pcSrc(pcSrc), .C_offset(C_offset), .redirect_imm(redirect_imm),
        .fetch_err(fetch_err)
    );

    always #5 CLK = ~CLK;

    // Instruction memory contents: address 0 holds a J-type word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h1800_0000;
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // Registered memory with mem_lat extra wait cycles; shares RST.
    always @(posedge CLK) begin
        if (RST) begin
            imem_ack   <= 1'b0;
            imem_rdata <= 32'h0;
            mem_cnt    <= 0;
        end else if (imem_ack) begin
            imem_ack <= 1'b0;
            mem_cnt  <= 0;
        end else if (imem_req && !mem_dead) begin
            if (mem_cnt >= mem_lat) begin
                imem_ack   <= 1'b1;
                imem_rdata <= mem_word(imem_addr);
                mem_cnt    <= 0;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end
    end

    // Next PC from the architectural rules, computed in wide arithmetic then wrapped.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic src,
                                               input logic coff, input logic [31:0] imm);
        longint unsigned t;
        if (!src) t = longint'(pc) + 1;
        else if (!coff) t = longint'(imm);
        else t = longint'(pc) + 1 + longint'(imm);
        return t[31:0];
    endfunction

    task automatic scramble_ctrl();
        pcSrc        = 1'($urandom);
        C_offset     = 1'($urandom);
        redirect_imm = $urandom;
    endtask

    task automatic wait_valid(input string tag);
        int   n = 0;
        logic addr_ok = 1'b1;
        while (!instr_valid && n < 40) begin
            if (imem_req && imem_addr !== exp_pc) addr_ok = 1'b0;
            @(negedge CLK);
            scramble_ctrl();
            n++;
        end
        total++;
        if (!instr_valid || !addr_ok) begin
            bad++;
            $display("FAIL %s wait_valid: valid=%b addr_ok=%b cycles=%0d required valid=1 addr=%h",
                     tag, instr_valid, addr_ok, n, exp_pc);
        end
    endtask

    // Called at a negedge with instr_valid=1 holding the instruction at exp_pc.
    task automatic do_handshake(input string tag, input int hold, input logic src,
                                input logic coff, input logic [31:0] imm);
        logic [31:0] h_instr;
        logic [31:0] h_pc;
        logic        held_ok = 1'b1;
        logic [31:0] w;
        w = mem_word(exp_pc);
        total++;
        if (instr !== w || pc_out !== exp_pc || opcode !== w[31:27]) begin
            bad++;
            $display("FAIL %s data: instr=%h pc=%h op=%b required instr=%h pc=%h op=%b",
                     tag, instr, pc_out, opcode, w, exp_pc, w[31:27]);
        end
        h_instr = instr;
        h_pc    = pc_out;
        for (int i = 0; i < hold; i++) begin
            instr_ready = 1'b0;
            scramble_ctrl();
            @(negedge CLK);
            if (instr !== h_instr || pc_out !== h_pc || imem_req !== 1'b0 || instr_valid !== 1'b1)
                held_ok = 1'b0;
        end
        if (hold > 0) begin
            total++;
            if (!held_ok) begin
                bad++;
                $display("FAIL %s hold: instr=%h pc=%h req=%b valid=%b required instr=%h pc=%h req=0 valid=1",
                         tag, instr, pc_out, imem_req, instr_valid, h_instr, h_pc);
            end
        end
        instr_ready  = 1'b1;
        pcSrc        = src;
        C_offset     = coff;
        redirect_imm = imm;
        exp_pc       = model_next(exp_pc, src, coff, imm);
        @(negedge CLK);
        instr_ready = 1'b0;
        scramble_ctrl();
        total++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            bad++;
            $display("FAIL %s next_req: valid=%b req=%b addr=%h required valid=0 req=1 addr=%h",
                     tag, instr_valid, imem_req, imem_addr, exp_pc);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        total++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || instr !== 32'h0 || opcode !== 5'h0 ||
            pc_out !== RESET_PC || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
            bad++;
            $display("FAIL reset: req=%b addr=%h instr=%h op=%b pc=%h valid=%b err=%b required all zero/RESET_PC",
                     imem_req, imem_addr, instr, opcode, pc_out, instr_valid, fetch_err);
        end
    endtask

    task automatic test_first_fetch();
        mem_lat = 0;
        exp_pc  = RESET_PC;
        RST     = 1'b0;
        @(negedge CLK);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_cycle1: req=%b addr=%h valid=%b required req=1 addr=%h valid=0",
                     imem_req, imem_addr, instr_valid, RESET_PC);
        end
        @(negedge CLK);
        total++;
        if (instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_cycle2: valid=%b required 0", instr_valid);
        end
        @(negedge CLK);
        total++;
        if (instr_valid !== 1'b1 || opcode !== fetch_unit_pkg::OPCODE_J || pc_out !== 32'h0 ||
            instr !== 32'h1800_0000) begin
            bad++;
            $display("FAIL first_cycle3: valid=%b op=%b pc=%h instr=%h required valid=1 op=00011 pc=0 instr=18000000",
                     instr_valid, opcode, pc_out, instr);
        end
    endtask

    task automatic test_hold();
        do_handshake("hold", 5, 1'b0, 1'b0, 32'h0);
        wait_valid("hold");
    endtask

    task automatic test_redirect();
        do_handshake("abs10", 0, 1'b1, 1'b0, 32'h10);
        wait_valid("abs10");
        do_handshake("rel_m2", 0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        wait_valid("rel_m2");
        do_handshake("abs40", 1, 1'b1, 1'b0, 32'h40);
        wait_valid("abs40");
    endtask

    task automatic test_wrap();
        do_handshake("to_max", 0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        wait_valid("to_max");
        do_handshake("wrap", 0, 1'b0, 1'b0, 32'h0);
        wait_valid("wrap");
    endtask

    task automatic test_back_to_back();
        int n;
        mem_lat = 0;
        for (int k = 0; k < 4; k++) begin
            do_handshake("b2b", 0, 1'b0, 1'b0, 32'h0);
            n = 0;
            while (!instr_valid && n < 10) begin
                @(negedge CLK);
                n++;
            end
            total++;
            if (n !== 2) begin
                bad++;
                $display("FAIL b2b_latency: cycles=%0d required 2", n);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            mem_lat = $urandom_range(0, 3);
            do_handshake("rand", $urandom_range(0, 3), 1'($urandom), 1'($urandom), $urandom);
            wait_valid("rand");
        end
    endtask

    task automatic test_reset_mid_req();
        int n = 0;
        mem_lat = 2;
        do_handshake("pre_rst", 0, 1'b0, 1'b0, 32'h0);
        while (!imem_ack && n < 20) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (imem_ack !== 1'b1 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_setup: ack=%b req=%b required ack=1 req=1", imem_ack, imem_req);
        end
        RST = 1'b1;
        @(negedge CLK);
        total++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== RESET_PC || instr !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid: valid=%b req=%b addr=%h instr=%h required valid=0 req=0 addr=%h instr=0",
                     instr_valid, imem_req, imem_addr, instr, RESET_PC);
        end
        RST    = 1'b0;
        exp_pc = RESET_PC;
        @(negedge CLK);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_refetch: req=%b addr=%h valid=%b required req=1 addr=%h valid=0",
                     imem_req, imem_addr, instr_valid, RESET_PC);
        end
        wait_valid("rst_mid");
        do_handshake("post_rst", 0, 1'b0, 1'b0, 32'h0);
        wait_valid("post_rst");
    endtask

    task automatic test_timeout();
        logic ok = 1'b1;
        RST      = 1'b1;
        mem_dead = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int c = 1; c <= 16; c++) begin
            @(negedge CLK);
            if (imem_req !== 1'b1 || fetch_err !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL timeout_wait: req=%b err=%b required req=1 err=0 for 16 cycles", imem_req, fetch_err);
        end
        ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (imem_req !== 1'b0 || fetch_err !== 1'b1) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL timeout_err: req=%b err=%b required req=0 err=1 sticky", imem_req, fetch_err);
        end
`else
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (imem_req !== 1'b1 || fetch_err !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL no_timeout: req=%b err=%b required req=1 err=0", imem_req, fetch_err);
        end
`endif
        RST      = 1'b1;
        mem_dead = 1'b0;
        @(negedge CLK);
        total++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear: err=%b req=%b required err=0 req=0", fetch_err, imem_req);
        end
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_hold();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid_req();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
